// File: rtl/sha1_round_ctrl_if.sv
// Handshake/bus bundle between the Wishbone loader side and the SHA-1 round sequencer.
// The master modport is the loader/datapath side; the slave modport is the sequencer.
interface sha1_round_ctrl_if;
    logic         start;
    logic         abort;
    logic [511:0] msg_block;
    logic         round_ready;
    logic         round_valid;
    logic [6:0]   round_idx;
    logic [31:0]  w_t;
    logic [31:0]  k_t;
    logic [1:0]   f_sel;
    logic         add_final;
    logic         busy;
    logic         done;
    logic         aborted;

    modport master (
        output start, abort, msg_block, round_ready,
        input  round_valid, round_idx, w_t, k_t, f_sel, add_final, busy, done, aborted
    );

    modport slave (
        input  start, abort, msg_block, round_ready,
        output round_valid, round_idx, w_t, k_t, f_sel, add_final, busy, done, aborted
    );
endinterface

// File: rtl/sha1_round_ctrl.sv
// SHA-1 round sequencer: walks rounds 0..79 over a 16-word sliding schedule window,
// then issues the final hash add and a done pulse. All outputs are registered.
module sha1_round_ctrl (
    input  logic             wb_clk_i,
    input  logic             reset_n,
    sha1_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t      state;
    logic [6:0]  t;
    logic [31:0] win [16];
    logic [31:0] mix;
    logic [31:0] w_new;
    logic [6:0]  t_next;

    function automatic logic [31:0] k_of(input logic [6:0] r);
        if (r < 7'd20)      return 32'h5A827999;
        else if (r < 7'd40) return 32'h6ED9EBA1;
        else if (r < 7'd60) return 32'h8F1BBCDC;
        else                return 32'hCA62C1D6;
    endfunction

    function automatic logic [1:0] f_of(input logic [6:0] r);
        if (r < 7'd20)      return 2'd0;
        else if (r < 7'd40) return 2'd1;
        else if (r < 7'd60) return 2'd2;
        else                return 2'd3;
    endfunction

    // W[t+16] from the window holding W[t..t+15]
    always_comb begin
        mix    = win[13] ^ win[8] ^ win[2] ^ win[0];
        w_new  = {mix[30:0], mix[31]};
        t_next = t + 7'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!reset_n) begin
            state           <= IDLE;
            t               <= '0;
            for (int unsigned j = 0; j < 16; j++) win[j] <= '0;
            bus.round_valid <= 1'b0;
            bus.round_idx   <= '0;
            bus.w_t         <= '0;
            bus.k_t         <= '0;
            bus.f_sel       <= '0;
            bus.add_final   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.aborted     <= 1'b0;
        end else begin
            bus.done      <= 1'b0;
            bus.aborted   <= 1'b0;
            bus.add_final <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        for (int unsigned j = 0; j < 16; j++) win[j] <= bus.msg_block[32*j +: 32];
                        t               <= '0;
                        state           <= ROUND;
                        bus.round_valid <= 1'b1;
                        bus.round_idx   <= '0;
                        bus.w_t         <= bus.msg_block[31:0];
                        bus.k_t         <= k_of(7'd0);
                        bus.f_sel       <= f_of(7'd0);
                        bus.busy        <= 1'b1;
                    end
                end
                ROUND: begin
                    if (bus.abort) begin
                        state           <= IDLE;
                        bus.aborted     <= 1'b1;
                        bus.busy        <= 1'b0;
                        bus.round_valid <= 1'b0;
                        bus.round_idx   <= '0;
                        bus.w_t         <= '0;
                        bus.k_t         <= '0;
                        bus.f_sel       <= '0;
                    end else if (bus.round_ready) begin
                        for (int unsigned j = 0; j < 15; j++) win[j] <= win[j+1];
                        win[15] <= w_new;
                        if (t == 7'd79) begin
                            state           <= FINAL;
                            bus.add_final   <= 1'b1;
                            bus.round_valid <= 1'b0;
                            bus.round_idx   <= '0;
                            bus.w_t         <= '0;
                            bus.k_t         <= '0;
                            bus.f_sel       <= '0;
                        end else begin
                            t             <= t_next;
                            bus.round_idx <= t_next;
                            bus.w_t       <= win[1];
                            bus.k_t       <= k_of(t_next);
                            bus.f_sel     <= f_of(t_next);
                        end
                    end
                end
                FINAL: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    if (bus.abort) bus.aborted <= 1'b1;
                    else           bus.done    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Directed bench for sha1_round_ctrl: an independent SHA-1 schedule model fills a
// scoreboard at each start; entries are popped and compared at each round acceptance.
module tb_sha1_round_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    sha1_round_ctrl_if bus ();

    sha1_round_ctrl dut (
        .wb_clk_i (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  idx;
        logic [31:0] w;
        logic [31:0] k;
        logic [1:0]  f;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] got_w [80];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] k_exp(input int r);
        case (r / 20)
            0:       return 32'h5A827999;
            1:       return 32'h6ED9EBA1;
            2:       return 32'h8F1BBCDC;
            default: return 32'hCA62C1D6;
        endcase
    endfunction

    task automatic push_model(input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] x;
        for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
        for (int i = 16; i < 80; i++) begin
            x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {x[30:0], x[31]};
        end
        for (int i = 0; i < 80; i++) begin
            exp_t e;
            e.idx = 7'(i);
            e.w   = w[i];
            e.k   = k_exp(i);
            e.f   = 2'(i / 20);
            sb.push_back(e);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_wt"}, {32'd0, bus.w_t}, 64'd0);
        chk({tag, "_kt"}, {32'd0, bus.k_t}, 64'd0);
        chk({tag, "_ctl"}, {50'd0, bus.round_valid, bus.round_idx, bus.f_sel,
                            bus.add_final, bus.busy, bus.done, bus.aborted}, 64'd0);
    endtask

    task automatic do_start(input logic [511:0] blk);
        sb.delete();
        for (int i = 0; i < 80; i++) got_w[i] = 'x;
        push_model(blk);
        bus.msg_block = blk;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("round0_valid", {63'd0, bus.round_valid}, 64'd1);
        chk("round0_idx", {57'd0, bus.round_idx}, 64'd0);
        chk("round0_done", {63'd0, bus.done}, 64'd0);
    endtask

    // Steps the block until done/aborted/reset; the start edge is not counted in cycles.
    task automatic run_block(input int stall_pct, input int abort_at, input int pulse_at,
                             input int reset_at, output int cycles, output int stalls,
                             output int adds, output int dones, output int aborts);
        bit fin;
        bit rst_hit;
        cycles = 0; stalls = 0; adds = 0; dones = 0; aborts = 0;
        fin = 1'b0;
        while (!fin && cycles < 1000) begin
            @(negedge clk);
            rst_hit = (reset_at >= 0) && bus.round_valid && (int'(bus.round_idx) == reset_at);
            bus.round_ready = (int'($urandom_range(99)) >= stall_pct);
            bus.start = (pulse_at >= 0) && bus.round_valid && (int'(bus.round_idx) == pulse_at);
            bus.abort = (abort_at >= 0) && bus.round_valid && (int'(bus.round_idx) == abort_at);
            if (rst_hit) reset_n = 1'b0;
            if (bus.round_valid && !bus.abort && !rst_hit) begin
                if (!bus.round_ready) stalls++;
                else if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    got_w[bus.round_idx] = bus.w_t;
                    chk("acc_idx", {57'd0, bus.round_idx}, {57'd0, e.idx});
                    chk("acc_w", {32'd0, bus.w_t}, {32'd0, e.w});
                    chk("acc_k", {32'd0, bus.k_t}, {32'd0, e.k});
                    chk("acc_f", {62'd0, bus.f_sel}, {62'd0, e.f});
                end
            end
            @(posedge clk);
            #1;
            cycles++;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            adds   += int'(bus.add_final);
            dones  += int'(bus.done);
            aborts += int'(bus.aborted);
            if (rst_hit) begin
                check_quiet("reset_mid");
                reset_n = 1'b1;
                fin = 1'b1;
            end
            if (bus.done || bus.aborted) fin = 1'b1;
        end
        if (!fin) chk("timeout", 64'(cycles), 64'd0);
        bus.round_ready = 1'b1;
    endtask

    task automatic idle_watch(input int n, output int adds, output int dones, output int aborts);
        adds = 0; dones = 0; aborts = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            adds   += int'(bus.add_final);
            dones  += int'(bus.done);
            aborts += int'(bus.aborted);
        end
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] rblk;
        int cyc, stl, adds, dones, aborts;

        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;
        for (int i = 0; i < 16; i++) rblk[32*i +: 32] = $urandom;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.msg_block = '0;
        bus.round_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // "abc" block, no stalls
        do_start(abc);
        run_block(0, -1, -1, -1, cyc, stl, adds, dones, aborts);
        chk("abc_latency", 64'(cyc + 1), 64'd82);
        chk("abc_add_once", 64'(adds), 64'd1);
        chk("abc_done_once", 64'(dones), 64'd1);
        chk("abc_sb_empty", 64'(sb.size()), 64'd0);
        chk("abc_w0", {32'd0, got_w[0]}, 64'h61626380);
        chk("abc_w15", {32'd0, got_w[15]}, 64'h00000018);
        chk("abc_w16", {32'd0, got_w[16]}, 64'hC2C4C700);
        chk("abc_w17", {32'd0, got_w[17]}, 64'h00000000);
        chk("abc_w18", {32'd0, got_w[18]}, 64'h00000030);

        // start in the done cycle, then random 30% stalls
        do_start(rblk);
        run_block(30, -1, -1, -1, cyc, stl, adds, dones, aborts);
        chk("stall_latency", 64'(cyc + 1), 64'(82 + stl));
        chk("stall_add_once", 64'(adds), 64'd1);
        chk("stall_done_once", 64'(dones), 64'd1);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);
        chk("stall_seen", 64'(stl > 0), 64'd1);

        // start pulsed while busy is ignored and not queued
        @(posedge clk);
        #1;
        do_start(abc);
        run_block(0, -1, 10, -1, cyc, stl, adds, dones, aborts);
        chk("pulse_latency", 64'(cyc + 1), 64'd82);
        chk("pulse_done_once", 64'(dones), 64'd1);
        chk("pulse_sb_empty", 64'(sb.size()), 64'd0);
        idle_watch(2, adds, dones, aborts);
        chk("pulse_not_queued", {63'd0, bus.busy}, 64'd0);

        // abort at t=37
        do_start(abc);
        run_block(0, 37, -1, -1, cyc, stl, adds, dones, aborts);
        chk("abort_pulse", 64'(aborts), 64'd1);
        chk("abort_rv", {63'd0, bus.round_valid}, 64'd0);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_cycles", 64'(cyc), 64'd38);
        chk("abort_no_add", 64'(adds), 64'd0);
        idle_watch(4, adds, dones, aborts);
        chk("abort_after_add", 64'(adds), 64'd0);
        chk("abort_after_done", 64'(dones), 64'd0);
        chk("abort_after_pulse", 64'(aborts), 64'd0);

        // abort in IDLE blocks start and does not pulse aborted
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("idle_abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("idle_abort_pulse", {63'd0, bus.aborted}, 64'd0);

        // reset at t=50, then a fresh block
        do_start(abc);
        run_block(0, -1, -1, 50, cyc, stl, adds, dones, aborts);
        chk("reset_cycles", 64'(cyc), 64'd51);
        idle_watch(3, adds, dones, aborts);
        chk("reset_no_done", 64'(dones), 64'd0);
        chk("reset_no_abort", 64'(aborts), 64'd0);
        check_quiet("reset_idle");
        do_start(abc);
        run_block(0, -1, -1, -1, cyc, stl, adds, dones, aborts);
        chk("rerun_latency", 64'(cyc + 1), 64'd82);
        chk("rerun_done_once", 64'(dones), 64'd1);
        chk("rerun_sb_empty", 64'(sb.size()), 64'd0);
        chk("rerun_w16", {32'd0, got_w[16]}, 64'hC2C4C700);
        chk("rerun_w18", {32'd0, got_w[18]}, 64'h00000030);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
